// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter: TXDATA / STATUS / BAUDDIV registers, a TX FIFO and a serializer FSM.
// Framing is 8N1 by default; defining UART_TX_PARITY_EN inserts an even-parity bit (8E1).
module uart_tx_mmio #(
  parameter logic [31:0] BASE_ADDR  = 32'h4000_0000,
  parameter logic [15:0] CLK_DIV    = 16'd434,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  wr_en_i,
  input  logic [31:0] wr_addr_i,
  input  logic [31:0] wr_data_i,
  input  logic [31:0] rd_addr_i,
  output logic [31:0] rd_data_o,
  output logic        tx_o
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  localparam logic [31:0] ADDR_TXDATA = BASE_ADDR;
  localparam logic [31:0] ADDR_STATUS = BASE_ADDR + 32'h4;
  localparam logic [31:0] ADDR_BAUD   = BASE_ADDR + 32'h8;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] ST_PARITY = 3'd3;
`endif
  localparam logic [2:0] ST_STOP   = 3'd4;

  // Register-interface decode
  logic wr_txdata;
  logic wr_status_clr;
  logic wr_baud;

  assign wr_txdata     = wr_en_i[0] && (wr_addr_i == ADDR_TXDATA);
  assign wr_status_clr = wr_en_i[0] && (wr_addr_i == ADDR_STATUS) && wr_data_i[3];
  assign wr_baud       = (|wr_en_i[1:0]) && (wr_addr_i == ADDR_BAUD);

  logic unused_bits;
  assign unused_bits = ^{wr_en_i[3:2], wr_data_i[31:16]};

  // BAUDDIV register
  logic [15:0] bauddiv_q, bauddiv_d;
  logic [15:0] baud_wr_val;

  always_comb begin
    baud_wr_val = bauddiv_q;
    if (wr_en_i[0]) baud_wr_val[7:0]  = wr_data_i[7:0];
    if (wr_en_i[1]) baud_wr_val[15:8] = wr_data_i[15:8];
    bauddiv_d = bauddiv_q;
    // A divisor of zero would stall the bit timer, so it is promoted to one.
    if (wr_baud) bauddiv_d = (baud_wr_val == 16'd0) ? 16'd1 : baud_wr_val;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bauddiv_q <= CLK_DIV;
    else        bauddiv_q <= bauddiv_d;
  end

  // TX FIFO. Handshake: push fires when TXDATA is written and there is space
  // (or the FSM pops on the same edge); pop fires when the FSM takes the head.
  logic [7:0]    fifo_mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          fifo_empty;
  logic          fifo_full;
  logic          push;
  logic          pop;
  logic [7:0]    fifo_head;
  logic          overflow_q, overflow_d;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign fifo_head  = fifo_mem_q[rd_ptr_q];
  assign push       = wr_txdata && (!fifo_full || pop);

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (!push && pop) count_d = count_q - CW'(1);
  end

  always_comb begin
    overflow_d = overflow_q;
    if (wr_txdata && fifo_full && !pop) overflow_d = 1'b1;
    else if (wr_status_clr)             overflow_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= wr_data_i[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Serializer FSM
  logic [2:0]  state_q, state_d;
  logic [15:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic        bit_done;
  logic [15:0] baud_load;
`ifdef UART_TX_PARITY_EN
  logic        parity_q, parity_d;
`endif

  assign bit_done  = (baud_cnt_q == 16'd0);
  assign baud_load = bauddiv_q - 16'd1;

  always_comb begin
    state_d    = state_q;
    baud_cnt_d = bit_done ? baud_cnt_q : baud_cnt_q - 16'd1;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    pop        = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          shift_d    = fifo_head;
          baud_cnt_d = baud_load;
          state_d    = ST_START;
`ifdef UART_TX_PARITY_EN
          parity_d   = ^fifo_head;
`endif
        end
      end
      ST_START: begin
        if (bit_done) begin
          bit_cnt_d  = 3'd0;
          baud_cnt_d = baud_load;
          state_d    = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          baud_cnt_d = baud_load;
          if (bit_cnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_done) begin
          baud_cnt_d = baud_load;
          state_d    = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (bit_done) begin
          // Chain straight into the next start bit so back-to-back frames carry no idle gap.
          if (!fifo_empty) begin
            pop        = 1'b1;
            shift_d    = fifo_head;
            baud_cnt_d = baud_load;
            state_d    = ST_START;
`ifdef UART_TX_PARITY_EN
            parity_d   = ^fifo_head;
`endif
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    case (state_q)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_d = parity_q;
`endif
      default:   tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      baud_cnt_q <= 16'd0;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'd0;
      tx_q       <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
`ifdef UART_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  assign tx_o = tx_q;

  // Read path is purely combinational from rd_addr_i
  logic [31:0] status_word;
  logic        busy;

  assign busy        = (state_q != ST_IDLE);
  assign status_word = {16'd0, {(8 - CW){1'b0}}, count_q, 4'd0,
                        overflow_q, fifo_empty, fifo_full, busy};

  always_comb begin
    rd_data_o = 32'd0;
    if (rd_addr_i == ADDR_STATUS)    rd_data_o = status_word;
    else if (rd_addr_i == ADDR_BAUD) rd_data_o = {16'd0, bauddiv_q};
  end

endmodule
